alu_arbiter: RTL and testbench

Shares the single EX-stage ALU between two requesters. Requester 0 is the pipeline EX stage; requester 1 is a secondary client such as branch-compare or address generation. Each requester uses a valid/ready handshake. The block drives the ALU operand and control lines combinationally, then registers the ALU result and flags into one response slot tagged with the requester id. It sits between the ID/EX register outputs and the EX/MEM register inputs.

---
 rtl/alu_arbiter_pkg.sv | 30 +++
 rtl/alu_arbiter_rr_arb2.sv | 47 ++++
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-client ALU arbiter.
// ALU op codes, flag bit positions and response-slot encoding.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1000;
    localparam logic [3:0] ALU_NAND = 4'b1001;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin, or r0 priority with r1 starvation guard.
// Produces a one-hot grant already qualified by request and enable.
module rr_arb2 #(
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic          last_grant;
    logic [CW-1:0] starve_cnt;
    logic          pick1;

    always_comb begin
        pick1 = 1'b0;
        if (MODE == 0)
            pick1 = req[1] & (~req[0] | ~last_grant);
        else
            pick1 = req[1] & (~req[0] | (starve_cnt == LIMIT));
        grant = 2'b00;
        if (en)
            grant = pick1 ? 2'b10 : {1'b0, req[0]};
    end

    // last_grant resets to r1 so the first tie goes to r0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            starve_cnt <= '0;
        end else begin
            if (|grant)
                last_grant <= grant[1];
            if (!req[1] || grant[1])
                starve_cnt <= '0;
            else if (en && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the EX-stage ALU between two valid/ready clients and
// registers the result into a single tagged response slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int TAG_W        = 4,
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [3:0]       r0_op,
    input  logic [31:0]      r0_a,
    input  logic [31:0]      r0_b,
    input  logic [TAG_W-1:0] r0_tag,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [3:0]       r1_op,
    input  logic [31:0]      r1_a,
    input  logic [31:0]      r1_b,
    input  logic [TAG_W-1:0] r1_tag,
    output logic [31:0]      alu_i1,
    output logic [31:0]      alu_i2,
    output logic [3:0]       alu_ctr,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_nzcv,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_nzcv
);

    logic       can_accept;
    logic       hs;
    logic [1:0] grant;
    logic [0:0] state;
    alu_req_t   sel;
    logic [TAG_W-1:0] sel_tag;

    assign can_accept = (state == SLOT_EMPTY) | rsp_ready;

    rr_arb2 #(
        .MODE         (MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({r1_valid, r0_valid}),
        .en    (can_accept & ~rst),
        .grant (grant)
    );

    assign r0_ready = grant[0];
    assign r1_ready = grant[1];
    assign hs       = |grant;

    always_comb begin
        sel     = '0;
        sel_tag = '0;
        unique case (1'b1)
            grant[0]: begin
                sel     = '{op: r0_op, a: r0_a, b: r0_b};
                sel_tag = r0_tag;
            end
            grant[1]: begin
                sel     = '{op: r1_op, a: r1_a, b: r1_b};
                sel_tag = r1_tag;
            end
            default: ;
        endcase
    end

    assign alu_i1  = sel.a;
    assign alu_i2  = sel.b;
    assign alu_ctr = sel.op;

    // Async reset drops an in-flight response without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SLOT_EMPTY;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            rsp_nzcv   <= '0;
        end else if (hs) begin
            state      <= SLOT_FULL;
            rsp_id     <= grant[1];
            rsp_tag    <= sel_tag;
            rsp_result <= alu_result;
            rsp_nzcv   <= alu_nzcv;
        end else if (rsp_ready) begin
            state <= SLOT_EMPTY;
        end
    end

    assign rsp_valid = (state == SLOT_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority
// instance, each driving a behavioural ALU.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [35:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h3: begin
                r = a - b;
                c = a < b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h4: r = {31'd0, $signed(a) < $signed(b)};
            4'h5: r = a << b[4:0];
            4'h6: r = a >> b[4:0];
            4'h7: r = a ^ b;
            4'h8: r = ~(a | b);
            4'h9: r = ~(a & b);
            default: r = 32'd0;
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    logic        rr_r0_valid, rr_r0_ready, rr_r1_valid, rr_r1_ready;
    logic [3:0]  rr_r0_op, rr_r1_op, rr_r0_tag, rr_r1_tag;
    logic [31:0] rr_r0_a, rr_r0_b, rr_r1_a, rr_r1_b;
    logic [31:0] rr_alu_i1, rr_alu_i2, rr_alu_result, rr_rsp_result;
    logic [3:0]  rr_alu_ctr, rr_alu_nzcv, rr_rsp_nzcv, rr_rsp_tag;
    logic        rr_rsp_valid, rr_rsp_ready, rr_rsp_id;

    logic        fp_r0_valid, fp_r0_ready, fp_r1_valid, fp_r1_ready;
    logic [3:0]  fp_r0_op, fp_r1_op, fp_r0_tag, fp_r1_tag;
    logic [31:0] fp_r0_a, fp_r0_b, fp_r1_a, fp_r1_b;
    logic [31:0] fp_alu_i1, fp_alu_i2, fp_alu_result, fp_rsp_result;
    logic [3:0]  fp_alu_ctr, fp_alu_nzcv, fp_rsp_nzcv, fp_rsp_tag;
    logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id;

    assign {rr_alu_nzcv, rr_alu_result} = alu_f(rr_alu_ctr, rr_alu_i1, rr_alu_i2);
    assign {fp_alu_nzcv, fp_alu_result} = alu_f(fp_alu_ctr, fp_alu_i1, fp_alu_i2);

    alu_arbiter #(.TAG_W(4), .MODE(0), .STARVE_LIMIT(4)) u_rr (
        .clk(clk), .rst(rst),
        .r0_valid(rr_r0_valid), .r0_ready(rr_r0_ready), .r0_op(rr_r0_op),
        .r0_a(rr_r0_a), .r0_b(rr_r0_b), .r0_tag(rr_r0_tag),
        .r1_valid(rr_r1_valid), .r1_ready(rr_r1_ready), .r1_op(rr_r1_op),
        .r1_a(rr_r1_a), .r1_b(rr_r1_b), .r1_tag(rr_r1_tag),
        .alu_i1(rr_alu_i1), .alu_i2(rr_alu_i2), .alu_ctr(rr_alu_ctr),
        .alu_result(rr_alu_result), .alu_nzcv(rr_alu_nzcv),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rr_rsp_ready), .rsp_id(rr_rsp_id),
        .rsp_tag(rr_rsp_tag), .rsp_result(rr_rsp_result), .rsp_nzcv(rr_rsp_nzcv)
    );

    alu_arbiter #(.TAG_W(4), .MODE(1), .STARVE_LIMIT(4)) u_fp (
        .clk(clk), .rst(rst),
        .r0_valid(fp_r0_valid), .r0_ready(fp_r0_ready), .r0_op(fp_r0_op),
        .r0_a(fp_r0_a), .r0_b(fp_r0_b), .r0_tag(fp_r0_tag),
        .r1_valid(fp_r1_valid), .r1_ready(fp_r1_ready), .r1_op(fp_r1_op),
        .r1_a(fp_r1_a), .r1_b(fp_r1_b), .r1_tag(fp_r1_tag),
        .alu_i1(fp_alu_i1), .alu_i2(fp_alu_i2), .alu_ctr(fp_alu_ctr),
        .alu_result(fp_alu_result), .alu_nzcv(fp_alu_nzcv),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_tag(fp_rsp_tag), .rsp_result(fp_rsp_result), .rsp_nzcv(fp_rsp_nzcv)
    );

    // Requester protocol: a pending request must hold valid and operands
    logic        p_rr0, p_rr1, p_fp0, p_fp1;
    logic [71:0] h_rr0, h_rr1, h_fp0, h_fp1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rr0 <= 1'b0; p_rr1 <= 1'b0; p_fp0 <= 1'b0; p_fp1 <= 1'b0;
        end else begin
            if (p_rr0 && (!rr_r0_valid || h_rr0 !== {rr_r0_op, rr_r0_a, rr_r0_b, rr_r0_tag})) begin
                errors++; $display("FAIL proto_rr_r0: valid=%b dropped while pending", rr_r0_valid);
            end
            if (p_rr1 && (!rr_r1_valid || h_rr1 !== {rr_r1_op, rr_r1_a, rr_r1_b, rr_r1_tag})) begin
                errors++; $display("FAIL proto_rr_r1: valid=%b dropped while pending", rr_r1_valid);
            end
            if (p_fp0 && (!fp_r0_valid || h_fp0 !== {fp_r0_op, fp_r0_a, fp_r0_b, fp_r0_tag})) begin
                errors++; $display("FAIL proto_fp_r0: valid=%b dropped while pending", fp_r0_valid);
            end
            if (p_fp1 && (!fp_r1_valid || h_fp1 !== {fp_r1_op, fp_r1_a, fp_r1_b, fp_r1_tag})) begin
                errors++; $display("FAIL proto_fp_r1: valid=%b dropped while pending", fp_r1_valid);
            end
            p_rr0 <= rr_r0_valid && !rr_r0_ready;
            p_rr1 <= rr_r1_valid && !rr_r1_ready;
            p_fp0 <= fp_r0_valid && !fp_r0_ready;
            p_fp1 <= fp_r1_valid && !fp_r1_ready;
            h_rr0 <= {rr_r0_op, rr_r0_a, rr_r0_b, rr_r0_tag};
            h_rr1 <= {rr_r1_op, rr_r1_a, rr_r1_b, rr_r1_tag};
            h_fp0 <= {fp_r0_op, fp_r0_a, fp_r0_b, fp_r0_tag};
            h_fp1 <= {fp_r1_op, fp_r1_a, fp_r1_b, fp_r1_tag};
        end
    end

    task automatic set_r0(input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
        rr_r0_valid = v; rr_r0_op = op; rr_r0_a = a; rr_r0_b = b; rr_r0_tag = tag;
    endtask

    task automatic set_r1(input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
        rr_r1_valid = v; rr_r1_op = op; rr_r1_a = a; rr_r1_b = b; rr_r1_tag = tag;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_r0(0, 0, 0, 0, 0);
        set_r1(0, 0, 0, 0, 0);
        rr_rsp_ready = 1'b1;
        fp_r0_valid = 0; fp_r0_op = 0; fp_r0_a = 0; fp_r0_b = 0; fp_r0_tag = 0;
        fp_r1_valid = 0; fp_r1_op = 0; fp_r1_a = 0; fp_r1_b = 0; fp_r1_tag = 0;
        fp_rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rr_rsp_valid, rr_rsp_id, rr_rsp_tag, rr_rsp_nzcv, rr_rsp_result} !== 42'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0",
                {rr_rsp_valid, rr_rsp_id, rr_rsp_tag, rr_rsp_nzcv, rr_rsp_result});
        end
        set_r0(1, 4'h2, 32'd1, 32'd2, 4'd1);
        set_r1(1, 4'h2, 32'd3, 32'd4, 4'd2);
        #1;
        checks++;
        if ({rr_r1_ready, rr_r0_ready} !== 2'b00) begin
            errors++; $display("FAIL ready_in_reset: got %b expected 00", {rr_r1_ready, rr_r0_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({rr_r1_ready, rr_r0_ready} !== 2'b01) begin
            errors++; $display("FAIL first_tie: got %b expected 01", {rr_r1_ready, rr_r0_ready});
        end
        next_cycle();
        checks++;
        if ({rr_rsp_valid, rr_rsp_id, rr_rsp_result} !== {1'b1, 1'b0, 32'd3}) begin
            errors++; $display("FAIL first_rsp: got %b/%b/%h expected 1/0/3",
                rr_rsp_valid, rr_rsp_id, rr_rsp_result);
        end
        rr_r0_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({rr_rsp_valid, rr_r1_ready, rr_r0_ready} !== 3'b000) begin
            errors++; $display("FAIL async_reset: got %b expected 000",
                {rr_rsp_valid, rr_r1_ready, rr_r0_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rr_r1_ready !== 1'b1) begin
            errors++; $display("FAIL r1_after_reset: got %b expected 1", rr_r1_ready);
        end
        next_cycle();
        checks++;
        if ({rr_rsp_id, rr_rsp_tag, rr_rsp_result} !== {1'b1, 4'd2, 32'd7}) begin
            errors++; $display("FAIL r1_rsp: got %b/%h/%h expected 1/2/7",
                rr_rsp_id, rr_rsp_tag, rr_rsp_result);
        end
        rr_r1_valid = 1'b0;
        next_cycle();
        checks++;
        if (rr_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rsp_clear: got %b expected 0", rr_rsp_valid);
        end
    endtask

    task automatic test_single;
        set_r0(1, 4'h2, 32'h7FFF_FFFF, 32'd1, 4'd3);
        #1;
        checks++;
        if ({rr_r0_ready, rr_alu_ctr, rr_alu_i1, rr_alu_i2} !== {1'b1, 4'h2, 32'h7FFF_FFFF, 32'd1}) begin
            errors++; $display("FAIL single_drive: got %b/%h/%h/%h expected 1/2/7fffffff/1",
                rr_r0_ready, rr_alu_ctr, rr_alu_i1, rr_alu_i2);
        end
        next_cycle();
        rr_r0_valid = 1'b0;
        checks++;
        if ({rr_rsp_valid, rr_rsp_id, rr_rsp_tag, rr_rsp_nzcv, rr_rsp_result} !==
            {1'b1, 1'b0, 4'd3, 4'b1001, 32'h8000_0000}) begin
            errors++; $display("FAIL single_rsp: got v%b id%b t%h f%b r%h expected v1 id0 t3 f1001 r80000000",
                rr_rsp_valid, rr_rsp_id, rr_rsp_tag, rr_rsp_nzcv, rr_rsp_result);
        end
        #1;
        checks++;
        if ({rr_alu_ctr, rr_alu_i1, rr_alu_i2} !== 68'd0) begin
            errors++; $display("FAIL idle_drive: got %h expected 0", {rr_alu_ctr, rr_alu_i1, rr_alu_i2});
        end
    endtask

    task automatic test_illegal_op;
        set_r1(1, 4'hF, 32'hFFFF_FFFF, 32'd0, 4'd9);
        #1;
        checks++;
        if ({rr_r1_ready, rr_alu_ctr} !== {1'b1, 4'hF}) begin
            errors++; $display("FAIL illegal_drive: got %b/%h expected 1/f", rr_r1_ready, rr_alu_ctr);
        end
        next_cycle();
        rr_r1_valid = 1'b0;
        checks++;
        if ({rr_rsp_id, rr_rsp_tag, rr_rsp_nzcv, rr_rsp_result} !== {1'b1, 4'd9, 4'b0100, 32'd0}) begin
            errors++; $display("FAIL illegal_rsp: got id%b t%h f%b r%h expected id1 t9 f0100 r0",
                rr_rsp_id, rr_rsp_tag, rr_rsp_nzcv, rr_rsp_result);
        end
    endtask

    task automatic test_round_robin;
        logic exp;
        set_r0(1, 4'h3, 32'd5, 32'd5, 4'd4);
        set_r1(1, 4'h1, 32'hF0, 32'h0F, 4'd5);
        for (int i = 0; i < 4; i++) begin
            exp = i[0];
            #1;
            checks++;
            if ({rr_r1_ready, rr_r0_ready} !== {exp, ~exp}) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b",
                    i, {rr_r1_ready, rr_r0_ready}, {exp, ~exp});
            end
            next_cycle();
            checks++;
            if ({rr_rsp_id, rr_rsp_nzcv, rr_rsp_result} !==
                (exp ? {1'b1, 4'b0000, 32'hFF} : {1'b0, 4'b0100, 32'd0})) begin
                errors++; $display("FAIL rr_rsp%0d: got id%b f%b r%h", i,
                    rr_rsp_id, rr_rsp_nzcv, rr_rsp_result);
            end
        end
        rr_r1_valid = 1'b0;
        #1;
        checks++;
        if (rr_r0_ready !== 1'b1) begin
            errors++; $display("FAIL rr_drain: got %b expected 1", rr_r0_ready);
        end
        next_cycle();
        rr_r0_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_backpressure;
        set_r0(1, 4'h2, 32'd10, 32'd20, 4'd6);
        next_cycle();
        checks++;
        if ({rr_rsp_valid, rr_rsp_result} !== {1'b1, 32'd30}) begin
            errors++; $display("FAIL bp_setup: got %b/%h expected 1/1e", rr_rsp_valid, rr_rsp_result);
        end
        set_r0(1, 4'h2, 32'd1, 32'd1, 4'd7);
        set_r1(1, 4'h1, 32'hF0, 32'h0F, 4'd8);
        rr_rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({rr_r1_ready, rr_r0_ready} !== 2'b00) begin
                errors++; $display("FAIL bp_ready%0d: got %b expected 00", i, {rr_r1_ready, rr_r0_ready});
            end
            next_cycle();
            checks++;
            if ({rr_rsp_valid, rr_rsp_id, rr_rsp_tag, rr_rsp_result} !== {1'b1, 1'b0, 4'd6, 32'd30}) begin
                errors++; $display("FAIL bp_hold%0d: got v%b id%b t%h r%h expected v1 id0 t6 r1e",
                    i, rr_rsp_valid, rr_rsp_id, rr_rsp_tag, rr_rsp_result);
            end
        end
        rr_rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rr_r1_ready, rr_r0_ready} !== 2'b10) begin
            errors++; $display("FAIL bp_release: got %b expected 10", {rr_r1_ready, rr_r0_ready});
        end
        next_cycle();
        rr_r1_valid = 1'b0;
        checks++;
        if ({rr_rsp_id, rr_rsp_tag, rr_rsp_result} !== {1'b1, 4'd8, 32'hFF}) begin
            errors++; $display("FAIL bp_rsp1: got id%b t%h r%h expected id1 t8 rff",
                rr_rsp_id, rr_rsp_tag, rr_rsp_result);
        end
        next_cycle();
        rr_r0_valid = 1'b0;
        checks++;
        if ({rr_rsp_id, rr_rsp_tag, rr_rsp_result} !== {1'b0, 4'd7, 32'd2}) begin
            errors++; $display("FAIL bp_rsp0: got id%b t%h r%h expected id0 t7 r2",
                rr_rsp_id, rr_rsp_tag, rr_rsp_result);
        end
    endtask

    task automatic test_starvation;
        logic exp;
        fp_r0_valid = 1; fp_r0_op = 4'h0; fp_r0_a = 32'hFF; fp_r0_b = 32'h0F; fp_r0_tag = 4'd1;
        fp_r1_valid = 1; fp_r1_op = 4'h7; fp_r1_a = 32'd1; fp_r1_b = 32'd3; fp_r1_tag = 4'd2;
        for (int i = 0; i < 10; i++) begin
            exp = (i == 4) || (i == 9);
            #1;
            checks++;
            if ({fp_r1_ready, fp_r0_ready} !== {exp, ~exp}) begin
                errors++; $display("FAIL starve_grant%0d: got %b expected %b",
                    i, {fp_r1_ready, fp_r0_ready}, {exp, ~exp});
            end
            next_cycle();
            checks++;
            if ({fp_rsp_id, fp_rsp_result} !== (exp ? {1'b1, 32'd2} : {1'b0, 32'h0F})) begin
                errors++; $display("FAIL starve_rsp%0d: got id%b r%h", i, fp_rsp_id, fp_rsp_result);
            end
        end
        fp_r1_valid = 1'b0;
        next_cycle();
        fp_r0_valid = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_illegal_op();
        test_round_robin();
        test_backpressure();
        test_starvation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
